keyboard_encoder: RTL

- Transmit end of the single-wire keypad link. Serialises one key event per frame onto `wire_out` by holding the line high during a key-specific window of a free-running frame counter.
- The same counter is exported as `frame_cnt` and feeds the keypad decoder's count input.
- Sits between the keypad scan/debounce logic (valid/ready key requests) and the clock/alarm front end.

---
 rtl/keyboard_encoder.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/keyboard_encoder.sv
// Transmit end of the single-wire keypad link: one key per frame, line high in a key-specific count window.
// Optional KEYENC_QUEUE_EN adds a 2-entry request FIFO so keys go out in consecutive frames.
module keyboard_encoder #(
  parameter int CNT_W       = 10,
  parameter int FRAME_LEN   = 256,
  parameter int HOLD_FRAMES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  output logic             key_ready,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             wire_out,
  output logic             busy,
  output logic             code_err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    SEND     = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [3:0]       HOLD = 4'(HOLD_FRAMES);

  state_t           state, state_nxt;
  logic [3:0]       code_q, code_nxt;
  logic [3:0]       left_q, left_nxt;
  logic [CNT_W-1:0] cnt_nxt, lo, hi;
  logic             at_last, take, illegal, req_avail;
  logic [3:0]       req_code;
  logic             wire_nxt, ready_nxt, busy_nxt;

  assign at_last = (frame_cnt == LAST);
  assign cnt_nxt = at_last ? '0 : frame_cnt + CNT_W'(1);
  assign take    = key_valid && key_ready;
  assign illegal = (key_code >= 4'd14);

`ifdef KEYENC_QUEUE_EN
  logic [3:0] fifo_mem [2];
  logic       wr_ptr, rd_ptr, push, pop;
  logic [1:0] fifo_cnt, fifo_cnt_nxt;

  // Illegal codes are dropped here so the FSM only ever sees sendable keys.
  assign push         = take && !illegal;
  assign req_avail    = (fifo_cnt != 2'd0);
  assign req_code     = fifo_mem[rd_ptr];
  assign fifo_cnt_nxt = fifo_cnt + {1'b0, push} - {1'b0, pop};
  assign ready_nxt    = (fifo_cnt_nxt != 2'd2);
  assign busy_nxt     = (state_nxt != IDLE) || (fifo_cnt_nxt != 2'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_cnt    <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= key_code;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt_nxt;
    end
  end
`else
  assign req_avail = take && !illegal;
  assign req_code  = key_code;
  assign ready_nxt = (state_nxt == IDLE);
  assign busy_nxt  = (state_nxt != IDLE);
`endif

  always_comb begin
    state_nxt = state;
    code_nxt  = code_q;
    left_nxt  = left_q;
`ifdef KEYENC_QUEUE_EN
    pop       = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (req_avail) begin
          state_nxt = WAIT_SOF;
          code_nxt  = req_code;
          left_nxt  = HOLD;
`ifdef KEYENC_QUEUE_EN
          pop       = 1'b1;
`endif
        end
      end
      WAIT_SOF: begin
        if (at_last) state_nxt = SEND;
      end
      SEND: begin
        if (at_last) begin
          left_nxt = left_q - 4'd1;
          if (left_q == 4'd1) begin
            state_nxt = IDLE;
`ifdef KEYENC_QUEUE_EN
            // Chain straight into the next queued key so no idle frame appears.
            if (req_avail) begin
              state_nxt = SEND;
              code_nxt  = req_code;
              left_nxt  = HOLD;
              pop       = 1'b1;
            end
`endif
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    if (code_nxt == 4'd13) begin
      lo = CNT_W'(160);
      hi = CNT_W'(190);
    end else begin
      lo = CNT_W'(10 * int'(code_nxt) + 7);
      hi = lo + CNT_W'(6);
    end
  end

  // Window is judged on the next count so wire_out lines up with frame_cnt.
  assign wire_nxt = (state_nxt == SEND) && (cnt_nxt >= lo) && (cnt_nxt <= hi);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      code_q    <= '0;
      left_q    <= '0;
      frame_cnt <= '0;
      wire_out  <= 1'b0;
      busy      <= 1'b0;
      code_err  <= 1'b0;
      key_ready <= 1'b1;
    end else begin
      state     <= state_nxt;
      code_q    <= code_nxt;
      left_q    <= left_nxt;
      frame_cnt <= cnt_nxt;
      wire_out  <= wire_nxt;
      busy      <= busy_nxt;
      code_err  <= take && illegal;
      key_ready <= ready_nxt;
    end
  end

endmodule
